// File: rtl/cpu_arb_pkg.sv
// Shared types and constants for the RAM port-A arbiter and its read-tag pipeline.
package cpu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  typedef logic req_id_t;

  localparam int      NUM_REQ = 2;
  localparam req_id_t ID_CPU  = 1'b0;
  localparam req_id_t ID_DMA  = 1'b1;

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line of {valid, requester id} matching the RAM read latency; the last
// stage is decoded into a one-hot read-valid per requester.
module rd_tag_pipe
  import cpu_arb_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_push_valid,
  input  req_id_t            i_push_id,
  output logic [NUM_REQ-1:0] o_rvalid
);

  logic [LATENCY-1:0] r_vld;
  req_id_t            r_id [LATENCY];

  // NOTE: both valid and id stages are reset; clearing the valids is what drops
  // in-flight reads, and clearing the ids keeps the decode free of X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) r_id[i] <= ID_CPU;
    end else begin
      r_vld[0] <= i_push_valid;
      r_id[0]  <= i_push_id;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_id[i]  <= r_id[i-1];
      end
    end
  end

  always_comb begin
    o_rvalid = '0;
    o_rvalid[r_id[LATENCY-1]] = r_vld[LATENCY-1];
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of RAM port A shared by the CPU load/store path and the
// blitter/DMA engine, with burst cap, ownership lock and tagged read return.
module ram_port_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int             CNT_W = 8;
  localparam logic [CNT_W:0] CAP   = (CNT_W + 1)'(MAX_BURST);

  arb_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  req_id_t            r_last, w_last_nxt;
  logic               w_gnt0, w_gnt1, w_acc0, w_acc1;
  logic               w_own_req, w_own_lock, w_oth_req, w_cap;
  arb_state_t         w_oth_state;
  req_id_t            w_oth_id, w_push_id;
  logic [CNT_W:0]     w_cnt_inc;
  logic               w_rd_push;
  logic [NUM_REQ-1:0] w_rvalid;

  assign w_gnt0 = (r_state == OWN0);
  assign w_gnt1 = (r_state == OWN1);
  assign w_acc0 = req0 & w_gnt0;
  assign w_acc1 = req1 & w_gnt1;

  // Owner/other views let one next-state branch serve both OWN states.
  assign w_own_req   = w_gnt1 ? req1  : req0;
  assign w_own_lock  = w_gnt1 ? lock1 : lock0;
  assign w_oth_req   = w_gnt1 ? req0  : req1;
  assign w_oth_state = w_gnt1 ? OWN0  : OWN1;
  assign w_oth_id    = w_gnt1 ? ID_CPU : ID_DMA;

  // The cap is judged on the count including this cycle's access, so the
  // access reaching MAX_BURST is performed and the switch lands on the next edge.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, (w_acc0 | w_acc1)};
  assign w_cap     = (w_cnt_inc >= CAP);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= ID_DMA;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        if (req0 && req1) begin
          w_state_nxt = (r_last == ID_DMA) ? OWN0 : OWN1;
          w_last_nxt  = (r_last == ID_DMA) ? ID_CPU : ID_DMA;
        end else if (req0) begin
          w_state_nxt = OWN0;
          w_last_nxt  = ID_CPU;
        end else if (req1) begin
          w_state_nxt = OWN1;
          w_last_nxt  = ID_DMA;
        end
      end
      OWN0, OWN1: begin
        if (!w_own_req && !w_own_lock) begin
          if (w_oth_req) begin
            w_state_nxt = w_oth_state;
            w_last_nxt  = w_oth_id;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (w_cap && !w_own_lock && w_oth_req) begin
          w_state_nxt = w_oth_state;
          w_last_nxt  = w_oth_id;
        end else if (w_cap && !w_oth_req) begin
          w_cnt_nxt = '0;
        end else if (w_cap) begin
          w_cnt_nxt = CNT_W'(MAX_BURST);
        end else begin
          w_cnt_nxt = w_cnt_inc[CNT_W-1:0];
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (w_acc0) begin
      ram_address = addr0;
      ram_data    = wdata0;
      ram_wren    = we0;
    end else if (w_acc1) begin
      ram_address = addr1;
      ram_data    = wdata1;
      ram_wren    = we1;
    end
  end

  assign w_rd_push = (w_acc0 & ~we0) | (w_acc1 & ~we1);
  assign w_push_id = w_gnt1 ? ID_DMA : ID_CPU;

  rd_tag_pipe #(
    .LATENCY (READ_LATENCY)
  ) u_rd_tag_pipe (
    .clk          (clock),
    .rst_n        (clear),
    .i_push_valid (w_rd_push),
    .i_push_id    (w_push_id),
    .o_rvalid     (w_rvalid)
  );

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign rvalid0 = w_rvalid[ID_CPU];
  assign rvalid1 = w_rvalid[ID_DMA];
  assign rdata0  = ram_q;
  assign rdata1  = ram_q;

endmodule
